// File: rtl/alu_pkg.sv
// Shared constants for the ALU control block: operation codes, ALU_op classes,
// funct encodings and the multiplier state type.
package alu_pkg;

    localparam int OP_W = 4;

    // ALU operation codes driven to the ALU
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // ALU_op classes from the main control unit
    localparam logic [1:0] CLS_ADD   = 2'b00;
    localparam logic [1:0] CLS_SUB   = 2'b01;
    localparam logic [1:0] CLS_RTYPE = 2'b10;
    localparam logic [1:0] CLS_RSVD  = 2'b11;

    // R-type funct field encodings
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    // Iterative multiplier sequencing
    typedef enum logic {
        MI_IDLE = 1'b0,
        MI_BUSY = 1'b1
    } mi_state_e;

endpackage

// File: rtl/mult_iter.sv
// Iterative shift-add multiplier on unsigned magnitudes. One multiplier bit is
// consumed per clock; the final product is sign-corrected on the way out.
module mult_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     mcand_in,
    input  logic [WIDTH-1:0]     mplier_in,
    input  logic                 sign_in,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;

    mi_state_e        state_q,  state_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic             sign_q,   sign_d;

    logic [WIDTH:0]   step_sum;
    logic [PW-1:0]    acc_step;

    // State register: sequencing, operands and the running partial product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MI_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
        end
    end

    // Next state: add the multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right by one
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        done_o   = 1'b0;

        step_sum = {1'b0, acc_q[PW-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {step_sum, acc_q[WIDTH-1:1]};

        case (state_q)
            MI_IDLE: begin
                if (start) begin
                    mcand_d  = mcand_in;
                    mplier_d = mplier_in;
                    sign_d   = sign_in;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = MI_BUSY;
                end
            end
            MI_BUSY: begin
                if (abort) begin
                    // Operands stay put; the product simply never emerges
                    count_d = '0;
                    state_d = MI_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        count_d = '0;
                        state_d = MI_IDLE;
                        done_o  = 1'b1;
                    end
                end
            end
            default: state_d = MI_IDLE;
        endcase
    end

    // Product is only meaningful while done_o is high (the final step)
    assign product_o = sign_q ? (~acc_step + PW'(1)) : acc_step;
    assign busy_o    = (state_q == MI_BUSY);

endmodule

// File: rtl/alu_control_mc.sv
// ALU control with full R-type decode, illegal-instruction flag, and an
// iterative multiplier owning the HI/LO registers.
module alu_control_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = alu_pkg::OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [1:0]       ALU_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [OP_W-1:0]  op,
    output logic             illegal,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [3:0]         op_code;
    logic               unknown;
    logic               is_rtype;
    logic               mult_sel;
    logic               hilo_sel;
    logic               signed_op;
    logic               issue;
    logic               idle_write;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               prod_sign;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operation decode: class first, then funct for R-type
    always_comb begin
        op_code = ALU_ADD;
        unknown = 1'b0;
        case (ALU_op)
            CLS_ADD: op_code = ALU_ADD;
            CLS_SUB: op_code = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: op_code = ALU_ADD;
                    F_SUB, F_SUBU: op_code = ALU_SUB;
                    F_AND:         op_code = ALU_AND;
                    F_OR:          op_code = ALU_OR;
                    F_XOR:         op_code = ALU_XOR;
                    F_NOR:         op_code = ALU_NOR;
                    F_SLT:         op_code = ALU_SLT;
                    F_SLTU:        op_code = ALU_SLTU;
                    F_JR, F_MULT, F_MULTU,
                    F_MFHI, F_MFLO, F_MTHI, F_MTLO: op_code = ALU_ADD;
                    default:       unknown = 1'b1;
                endcase
            end
            default: unknown = 1'b1;
        endcase
    end

    assign op      = OP_W'(op_code);
    assign illegal = valid & unknown;

    // Instruction classes that interact with the multiplier / HI-LO
    always_comb begin
        is_rtype  = (ALU_op == CLS_RTYPE);
        mult_sel  = is_rtype & ((funct == F_MULT) | (funct == F_MULTU));
        hilo_sel  = is_rtype & ((funct == F_MFHI) | (funct == F_MFLO) |
                                (funct == F_MTHI) | (funct == F_MTLO));
        signed_op = (funct == F_MULT);
        stall     = mul_busy & valid & (mult_sel | hilo_sel);
        issue     = valid & mult_sel & ~mul_busy & ~flush;
        idle_write = valid & is_rtype & ~mul_busy & ~flush;
        // Magnitudes for signed multiply; the most-negative value maps to 2^(W-1)
        a_mag     = (signed_op && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag     = (signed_op && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        prod_sign = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
    end

    mult_iter #(
        .WIDTH (WIDTH)
    ) u_mult_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (issue),
        .abort     (flush),
        .mcand_in  (a_mag),
        .mplier_in (b_mag),
        .sign_in   (prod_sign),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // HI/LO update: product on completion, otherwise mthi/mtlo when idle
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = mul_done;
        if (mul_done) begin
            hi_d = mul_product[2*WIDTH-1:WIDTH];
            lo_d = mul_product[WIDTH-1:0];
        end else if (idle_write && funct == F_MTHI) begin
            hi_d = a;
        end else if (idle_write && funct == F_MTLO) begin
            lo_d = a;
        end
    end

    // HI/LO and done-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    assign busy = mul_busy;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: decode table, multiply latency and
// results, stall rules, flush, back-to-back issue and asynchronous reset.
module tb_alu_control_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [1:0]   ALU_op = 2'b00;
    logic [5:0]   funct = 6'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic [3:0]   op;
    logic         illegal;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int errors = 0;
    int checks = 0;

    // Reference HI/LO contents
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    alu_control_mc #(.WIDTH(W), .OP_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (valid),
        .ALU_op  (ALU_op),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .op      (op),
        .illegal (illegal),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid  = 1'b0;
        ALU_op = 2'b00;
        funct  = 6'd0;
        a      = '0;
        b      = '0;
        flush  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference decode straight from the operation table
    function automatic void ref_decode(input logic v, input logic [1:0] cls, input logic [5:0] f,
                                       output logic [3:0] o, output logic ill);
        o   = 4'b0010;
        ill = 1'b0;
        if (cls == 2'b01) o = 4'b0110;
        else if (cls == 2'b11) ill = v;
        else if (cls == 2'b10) begin
            case (f)
                6'b100000, 6'b100001: o = 4'b0010;
                6'b100010, 6'b100011: o = 4'b0110;
                6'b100100: o = 4'b0000;
                6'b100101: o = 4'b0001;
                6'b100110: o = 4'b0011;
                6'b100111: o = 4'b1100;
                6'b101010: o = 4'b0111;
                6'b101011: o = 4'b1000;
                6'b001000, 6'b011000, 6'b011001,
                6'b010000, 6'b010010, 6'b010001, 6'b010011: o = 4'b0010;
                default: ill = v;
            endcase
        end
    endfunction

    // Reference product with plain 64-bit arithmetic
    function automatic logic [63:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        longint sx, sy;
        longint unsigned ux, uy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        ux = {32'd0, x};
        uy = {32'd0, y};
        return 64'(ux * uy);
    endfunction

    task automatic present_mult(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        valid  = 1'b1;
        ALU_op = 2'b10;
        funct  = sgn ? 6'b011000 : 6'b011001;
        a      = x;
        b      = y;
    endtask

    // Starting one cycle after the issue edge, count busy cycles and check the result
    task automatic wait_done(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn, input string name);
        logic [63:0] p;
        int n = 0;
        int early_done = 0;
        p = ref_product(x, y, sgn);
        while (busy === 1'b1 && n < W + 10) begin
            if (done !== 1'b0) early_done++;
            n++;
            tick();
        end
        chk({name, "_busy_cycles"}, 64'(n), 64'(W));
        chk({name, "_early_done"}, 64'(early_done), 64'd0);
        chk({name, "_done"}, 64'(done), 64'd1);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        chk({name, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        $display("mult %s a=%h b=%h signed=%0d -> hi=%h lo=%h", name, x, y, sgn, hi, lo);
        tick();
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic run_mult(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn, input string name);
        present_mult(x, y, sgn);
        #1;
        chk({name, "_issue_stall"}, 64'(stall), 64'd0);
        tick();
        idle_inputs();
        wait_done(x, y, sgn, name);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        tick();
        $display("reset released");
    endtask

    task automatic test_decode();
        logic [5:0] fl [17] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b001000, 6'b011000,
                                6'b011001, 6'b010000, 6'b010010, 6'b010001, 6'b010011};
        logic [3:0] eo;
        logic       ei;
        int         bad = 0;
        // Flush keeps any decoded mult/mthi/mtlo from touching state
        flush = 1'b1;
        for (int i = 0; i < 17; i++) begin
            valid = 1'b1; ALU_op = 2'b10; funct = fl[i];
            #1;
            ref_decode(valid, ALU_op, funct, eo, ei);
            chk($sformatf("decode_f%b", funct), {op, illegal}, {eo, ei});
        end
        for (int c = 0; c < 4; c++) begin
            for (int v = 0; v < 2; v++) begin
                valid = v[0]; ALU_op = c[1:0]; funct = 6'b111111;
                #1;
                ref_decode(valid, ALU_op, funct, eo, ei);
                chk($sformatf("decode_cls%0d_v%0d", c, v), {op, illegal}, {eo, ei});
            end
        end
        for (int i = 0; i < 200; i++) begin
            valid = 1'($urandom); ALU_op = 2'($urandom); funct = 6'($urandom);
            #1;
            ref_decode(valid, ALU_op, funct, eo, ei);
            if ({op, illegal} !== {eo, ei}) begin
                bad++;
                $display("FAIL decode_rand: v=%0d cls=%b f=%b got %b/%0d expected %b/%0d",
                         valid, ALU_op, funct, op, illegal, eo, ei);
            end
        end
        checks++;
        if (bad != 0) errors++;
        $display("decode sweep done, random mismatches=%0d", bad);
        idle_inputs();
        tick();
        chk("decode_no_side_effect", {64'(busy), 64'(hi), 64'(lo)} == {64'd0, 64'(exp_hi), 64'(exp_lo)} ? 64'd1 : 64'd0, 64'd1);
    endtask

    task automatic test_mult_vectors();
        logic [W-1:0] x, y;
        bit s;
        run_mult(32'hFFFFFFFD, 32'h00000007, 1'b1, "neg3x7");
        run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
        run_mult(32'h80000000, 32'hFFFFFFFF, 1'b1, "minneg_x_m1");
        run_mult(32'h80000000, 32'h80000000, 1'b1, "minneg_sq");
        for (int i = 0; i < 6; i++) begin
            x = $urandom; y = $urandom; s = 1'($urandom);
            run_mult(x, y, s, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] x, y, mval;
        logic [63:0] p;
        int stall_bad = 0;
        x = $urandom; y = $urandom; mval = $urandom;
        p = ref_product(x, y, 1'b1);
        present_mult(x, y, 1'b1);
        tick();
        idle_inputs();
        for (int c = 1; c <= W; c++) begin
            if (c == 3) begin
                valid = 1'b1; ALU_op = 2'b00; funct = 6'd0;
                #1;
                chk("stall_add_during_busy", {60'd0, op}, 64'b0010);
                chk("stall_add_no_stall", 64'(stall), 64'd0);
            end else if (c == 4) begin
                valid = 1'b1; ALU_op = 2'b10; funct = 6'b010001; a = mval;
                #1;
                chk("stall_mthi_busy", 64'(stall), 64'd1);
            end else if (c >= 5) begin
                valid = 1'b1; ALU_op = 2'b10; funct = 6'b010010;
                #1;
                if (stall !== 1'b1) stall_bad++;
            end else begin
                idle_inputs();
            end
            tick();
        end
        chk("stall_mflo_held", 64'(stall_bad), 64'd0);
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        chk("stall_release_on_done", {62'd0, stall, done}, 64'b01);
        chk("stall_hilo_product", {hi, lo}, {exp_hi, exp_lo});
        $display("stall test: mflo released at done, lo=%h", lo);
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        int done_seen = 0;
        valid = 1'b1; ALU_op = 2'b10; funct = 6'b010001; a = 32'h12345678;
        tick();
        exp_hi = 32'h12345678;
        chk("mthi_write", 64'(hi), 64'(exp_hi));
        valid = 1'b1; ALU_op = 2'b10; funct = 6'b010011; a = $urandom;
        exp_lo = a;
        tick();
        chk("mtlo_write", 64'(lo), 64'(exp_lo));
        // Flush in IDLE blocks mthi and issue
        valid = 1'b1; ALU_op = 2'b10; funct = 6'b010001; a = 32'hDEADBEEF; flush = 1'b1;
        tick();
        chk("flush_blocks_mthi", 64'(hi), 64'(exp_hi));
        present_mult(32'd5, 32'd6, 1'b0); flush = 1'b1;
        tick();
        chk("flush_blocks_issue", 64'(busy), 64'd0);
        // Flush at busy cycle 10
        idle_inputs();
        present_mult($urandom, $urandom, 1'b1);
        tick();
        idle_inputs();
        repeat (9) tick();
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_after", 64'(busy), 64'd0);
        for (int i = 0; i < W + 4; i++) begin
            if (done !== 1'b0) done_seen++;
            tick();
        end
        chk("flush_no_done", 64'(done_seen), 64'd0);
        chk("flush_hilo_kept", {hi, lo}, {exp_hi, exp_lo});
        // Flush on the completion edge wins
        present_mult($urandom, $urandom, 1'b0);
        tick();
        idle_inputs();
        repeat (W - 1) tick();
        chk("flush_last_busy", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_completion_edge", {62'd0, busy, done}, 64'd0);
        chk("flush_completion_hilo", {hi, lo}, {exp_hi, exp_lo});
        $display("flush test: hi=%h lo=%h", hi, lo);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x1, y1, x2, y2;
        logic [63:0] p1;
        x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom;
        p1 = ref_product(x1, y1, 1'b0);
        present_mult(x1, y1, 1'b0);
        tick();
        idle_inputs();
        repeat (W - 1) tick();
        present_mult(x2, y2, 1'b1);
        #1;
        chk("b2b_stall_last_cycle", 64'(stall), 64'd1);
        tick();
        exp_hi = p1[63:32];
        exp_lo = p1[31:0];
        chk("b2b_first_done", {62'd0, busy, done}, 64'b01);
        chk("b2b_first_hilo", {hi, lo}, {exp_hi, exp_lo});
        chk("b2b_second_unstalled", 64'(stall), 64'd0);
        $display("b2b first: hi=%h lo=%h", hi, lo);
        tick();
        idle_inputs();
        chk("b2b_second_issued", 64'(busy), 64'd1);
        wait_done(x2, y2, 1'b1, "b2b_second");
    endtask

    task automatic test_reset_mid();
        present_mult($urandom, $urandom, 1'b1);
        tick();
        idle_inputs();
        repeat (19) tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_hi = '0;
        exp_lo = '0;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        chk("rstmid_hilo", {hi, lo}, 64'd0);
        $display("async reset mid-multiply: busy=%0d hi=%h lo=%h", busy, hi, lo);
        #1;
        rst_n = 1'b1;
        tick();
        run_mult(32'hFFFFFFF0, 32'h00001234, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mult_vectors();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
